pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture block: the receive side of the PWM generator. It samples an external PWM waveform on `MClk` and measures its period and high time in `MClk` cycles. It publishes each completed measurement with a one-cycle `Valid` strobe. It is used for loopback self-test of the generator and for reading external PWM sources on the Zedboard.

## Interface
Parameters:
- `CW`, 16: width of the period and high-time counters and outputs.

Ports:
- `MClk`  in  1  system clock; all logic runs on its rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  level; 0 holds the capture engine idle with counters cleared.
- `PwmIn`  in  1  asynchronous PWM input; no phase relation to `MClk`.
- `Period`  out  CW  last measured period in `MClk` cycles; reset 0.
- `HighTime`  out  CW  last measured high time in `MClk` cycles; reset 0.
- `Valid`  out  1  one-cycle pulse when `Period`/`HighTime` update; reset 0.
- `Timeout`  out  1  one-cycle pulse when no rising edge is seen within 2^CW-1 cycles; reset 0.
- `StuckLevel`  out  1  synchronized `PwmIn` level captured at the last `Timeout`; reset 0.

## Operation
- **Input synchronizer:** 2-FF synchronizer on `PwmIn` produces `PwmSync`. The `PwmPrev` register holds the previous value.
  - Rise = `PwmSync & ~PwmPrev`.
  - Fall = `~PwmSync & PwmPrev`.
- **States:**
  - IDLE: `Enable`=0; `PerCnt`=`HighCnt`=0. Go to ARM when `Enable`=1.
  - ARM: wait for the first Rise. On Rise, set `PerCnt`<=1 and `HighCnt`<=1, then go to MEASURE. No output update.
  - MEASURE:
    - `PerCnt` increments every cycle.
    - `HighCnt` increments while `PwmSync`=1 and no Fall has been seen since the last Rise. It freezes at Fall.
    - On Rise: `Period`<=`PerCnt`, `HighTime`<=`HighCnt`, `Valid`<=1, then restart `PerCnt`<=1 and `HighCnt`<=1. Stay in MEASURE.
- **Result:** for a waveform with N cycles high out of P cycles total, `Period`=P and `HighTime`=N exactly.
- **Saturation:** if `PerCnt` reaches 2^CW-1 in MEASURE or ARM without a Rise:
  - `Timeout`<=1 and `StuckLevel`<=`PwmSync`.
  - Go to ARM with counters cleared.
  - `Period`/`HighTime` hold their values.
  - ARM uses its own free-running count for this check.
- **Rise on the saturation cycle:** Timeout wins. No `Valid` is produced and the state goes to ARM. The next Rise is treated as the first Rise.
- **`Enable` deasserted in any state:** next state is IDLE and the counters clear. `Period`, `HighTime` and `StuckLevel` hold their values. No `Valid` or `Timeout` is issued.
- **Re-enable:** always starts in ARM. The first period after enable is discarded.
- **Exclusivity:** `Valid` and `Timeout` are never high in the same cycle.

## Timing
- **`PwmIn` to Rise:** `PwmIn` is first sampled high at MClk edge t0. Rise is true between t1 and t2.
- **Output update:** `Period`, `HighTime` and `Valid` update at edge t2. `Valid` is high for exactly one cycle after t2. Latency is 2 edges, or 4 edges with the filter compiled in.
- **Minimum measurable pulse:** 1 cycle high and 1 cycle low (Period=2, HighTime=1). Shorter pulses are lost in the synchronizer.
- **Output stability:** `Period` and `HighTime` are stable from the `Valid` pulse until the next `Valid`.
- **Reset:** asynchronous assertion clears all registers immediately, including the synchronizer. Release is synchronous to `MClk`; the first state after release is IDLE.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined:
  - A glitch filter sits after the synchronizer. The filtered level changes only after `PwmSync` has held the new value for 3 consecutive cycles.
  - Rise/Fall detection latency grows by 2 cycles.
  - Pulses of 1 or 2 cycles are rejected.
  - Measured Period and HighTime are unchanged for input pulses of 3 or more cycles.
- Undefined: no filter; behaviour exactly as above.

## Test plan
- Reset with `Enable`=1 and PwmIn toggling: all outputs 0 during reset. After release, no `Valid` before the second Rise.
- PwmIn with 25 cycles high / 75 low, repeated 4 times: 3 `Valid` pulses, each with `Period`=100 and `HighTime`=25.
- Change to 1 high / 1 low: `Period`=2, `HighTime`=1. With `PWM_CAPTURE_FILTER_EN`: no `Valid`, `Timeout` after 65535 cycles.
- PwmIn held at 1 after a valid measurement: one `Timeout` pulse 65535 cycles after the last Rise, `StuckLevel`=1, previous `Period`/`HighTime` held. Restarting 10/40 gives `Period`=50 on the second subsequent Rise.
- Drop `Enable` mid-high-phase for 5 cycles, then re-enable with a 30/70 waveform: no `Valid` during the gap. First `Valid` after one full discarded period, with `Period`=100 and `HighTime`=30.
- Assert `nReset` asynchronously between clock edges mid-measure: outputs are 0 immediately, with no glitch `Valid` after release.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in MClk cycles.
// Optional glitch filter after the synchronizer is compiled in with PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CW = 16
) (
    input  logic          MClk,
    input  logic          nReset,
    input  logic          Enable,
    input  logic          PwmIn,
    output logic [CW-1:0] Period,
    output logic [CW-1:0] HighTime,
    output logic          Valid,
    output logic          Timeout,
    output logic          StuckLevel
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_MAX  = '1;
    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic          w_level;
    logic          w_rise;
    logic          w_fall;

    state_t        r_state;
    logic [CW-1:0] r_per_cnt;
    logic [CW-1:0] r_high_cnt;
    logic [CW-1:0] r_arm_cnt;
    logic          r_fell;
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_high_time;
    logic          r_valid;
    logic          r_timeout;
    logic          r_stuck;

    always_ff @(posedge MClk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= PwmIn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic r_hist1;
    logic r_hist2;

    always_ff @(posedge MClk or negedge nReset) begin
        if (!nReset) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
        end
    end

    // r_prev doubles as the held filtered level; it only follows three agreeing samples.
    always_comb begin
        w_level = r_prev;
        if ((r_sync2 == r_hist1) && (r_hist1 == r_hist2)) begin
            w_level = r_sync2;
        end
    end
`else
    assign w_level = r_sync2;
`endif

    assign w_rise = w_level & ~r_prev;
    assign w_fall = ~w_level & r_prev;

    always_ff @(posedge MClk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_IDLE;
            r_per_cnt   <= C_ZERO;
            r_high_cnt  <= C_ZERO;
            r_arm_cnt   <= C_ZERO;
            r_fell      <= 1'b0;
            r_period    <= C_ZERO;
            r_high_time <= C_ZERO;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (!Enable) begin
                r_state    <= S_IDLE;
                r_per_cnt  <= C_ZERO;
                r_high_cnt <= C_ZERO;
                r_arm_cnt  <= C_ZERO;
                r_fell     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_ARM;
                        r_arm_cnt <= C_ZERO;
                    end
                    S_ARM: begin
                        // Saturation beats a simultaneous rise; the next rise re-arms.
                        if (r_arm_cnt == C_MAX) begin
                            r_timeout <= 1'b1;
                            r_stuck   <= r_sync2;
                            r_arm_cnt <= C_ZERO;
                        end else if (w_rise) begin
                            r_state    <= S_MEASURE;
                            r_per_cnt  <= C_ONE;
                            r_high_cnt <= C_ONE;
                            r_fell     <= 1'b0;
                            r_arm_cnt  <= C_ZERO;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + C_ONE;
                        end
                    end
                    S_MEASURE: begin
                        if (r_per_cnt == C_MAX) begin
                            r_timeout  <= 1'b1;
                            r_stuck    <= r_sync2;
                            r_state    <= S_ARM;
                            r_per_cnt  <= C_ZERO;
                            r_high_cnt <= C_ZERO;
                            r_arm_cnt  <= C_ZERO;
                            r_fell     <= 1'b0;
                        end else if (w_rise) begin
                            r_period    <= r_per_cnt;
                            r_high_time <= r_high_cnt;
                            r_valid     <= 1'b1;
                            r_per_cnt   <= C_ONE;
                            r_high_cnt  <= C_ONE;
                            r_fell      <= 1'b0;
                        end else begin
                            r_per_cnt <= r_per_cnt + C_ONE;
                            if (w_fall) begin
                                r_fell <= 1'b1;
                            end else if (w_level && !r_fell) begin
                                r_high_cnt <= r_high_cnt + C_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Period     = r_period;
    assign HighTime   = r_high_time;
    assign Valid      = r_valid;
    assign Timeout    = r_timeout;
    assign StuckLevel = r_stuck;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: vector table of waveforms plus hand-written timeout,
// enable-gap and asynchronous-reset sequences.
module tb_pwm_capture;

    localparam int CW = 16;

    logic          MClk = 1'b0;
    logic          nReset;
    logic          Enable;
    logic          PwmIn;
    logic [CW-1:0] Period;
    logic [CW-1:0] HighTime;
    logic          Valid;
    logic          Timeout;
    logic          StuckLevel;

    int errors    = 0;
    int checks    = 0;
    int valid_cnt = 0;
    int exp_p     = 0;
    int exp_h     = 0;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_v;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[7];

    always #5 MClk = ~MClk;

    pwm_capture #(.CW(CW)) dut (
        .MClk       (MClk),
        .nReset     (nReset),
        .Enable     (Enable),
        .PwmIn      (PwmIn),
        .Period     (Period),
        .HighTime   (HighTime),
        .Valid      (Valid),
        .Timeout    (Timeout),
        .StuckLevel (StuckLevel)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Hold PwmIn at v for n clock cycles; called just after a rising edge.
    task automatic drive(input logic v, input int n);
        PwmIn = v;
        repeat (n) begin
            @(posedge MClk);
            #1;
        end
    endtask

    task automatic restart_enable();
        Enable = 1'b0;
        drive(1'b0, 4);
        Enable = 1'b1;
        drive(1'b0, 4);
    endtask

    always @(negedge MClk) begin
        if (Valid) begin
            valid_cnt++;
            check("valid_period", Period, exp_p);
            check("valid_hightime", HighTime, exp_h);
        end
        if (Valid || Timeout) begin
            check("valid_timeout_exclusive", Valid & Timeout, 0);
        end
    end

    initial begin
        int base;
        int got;
        int seen;
        int k;

        vecs[0] = '{25, 75, 4, 3, 100, 25};
        vecs[1] = '{1, 1, 6, 5, 2, 1};
        vecs[2] = '{10, 40, 3, 2, 50, 10};
        vecs[3] = '{30, 70, 3, 2, 100, 30};
        vecs[4] = '{3, 5, 4, 3, 8, 3};
        vecs[5] = '{1, 2, 3, 2, 3, 1};
        vecs[6] = '{7, 1, 3, 2, 8, 7};

        // Reset with Enable high and the input toggling
        nReset = 1'b0;
        Enable = 1'b1;
        PwmIn  = 1'b0;
        repeat (6) begin
            @(posedge MClk);
            #1;
            PwmIn = ~PwmIn;
        end
        @(negedge MClk);
        check("reset_period", Period, 0);
        check("reset_hightime", HighTime, 0);
        check("reset_valid", Valid, 0);
        check("reset_timeout", Timeout, 0);
        check("reset_stuck", StuckLevel, 0);
        @(posedge MClk);
        #1;
        PwmIn  = 1'b0;
        nReset = 1'b1;
        drive(1'b0, 3);
        exp_p = 10;
        exp_h = 5;
        base  = valid_cnt;
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("no_valid_first_rise", valid_cnt - base, 0);
        drive(1'b1, 5);
        drive(1'b0, 5);
        check("valid_second_rise", valid_cnt - base, 1);

        // Table of waveforms
        for (int v = 0; v < 7; v++) begin
            restart_enable();
            exp_p = vecs[v].exp_p;
            exp_h = vecs[v].exp_h;
            base  = valid_cnt;
            for (int r = 0; r < vecs[v].reps; r++) begin
                drive(1'b1, vecs[v].hi);
                drive(1'b0, vecs[v].lo);
            end
            drive(1'b0, 4);
            check($sformatf("vec%0d_valid_count", v), valid_cnt - base, vecs[v].exp_v);
            check($sformatf("vec%0d_period", v), Period, vecs[v].exp_p);
            check($sformatf("vec%0d_hightime", v), HighTime, vecs[v].exp_h);
        end

        // Input stuck high after a valid 10/40 measurement
        restart_enable();
        exp_p = 50;
        exp_h = 10;
        drive(1'b1, 10);
        drive(1'b0, 40);
        PwmIn = 1'b1;
        base  = valid_cnt;
        got   = 0;
        for (int i = 0; i < 12 && got == 0; i++) begin
            @(negedge MClk);
            #1;
            if (valid_cnt > base) got = 1;
        end
        check("stuck_valid_seen", got, 1);
        k    = 0;
        seen = 0;
        while (k < 70000 && seen == 0) begin
            @(posedge MClk);
            k++;
            @(negedge MClk);
            if (Timeout) seen = 1;
        end
        check("timeout_seen", seen, 1);
        check("timeout_latency", k, 65535);
        check("timeout_stuck_level", StuckLevel, 1);
        check("timeout_period_held", Period, 50);
        check("timeout_hightime_held", HighTime, 10);
        check("timeout_no_extra_valid", valid_cnt - base, 1);
        @(posedge MClk);
        @(negedge MClk);
        check("timeout_one_cycle", Timeout, 0);
        @(posedge MClk);
        #1;

        // Restart 10/40: only the second rise produces a result
        base = valid_cnt;
        drive(1'b0, 40);
        drive(1'b1, 10);
        drive(1'b0, 40);
        check("restart_first_rise_silent", valid_cnt - base, 0);
        drive(1'b1, 10);
        drive(1'b0, 40);
        check("restart_second_rise_valid", valid_cnt - base, 1);
        check("restart_period", Period, 50);

        // Enable dropped mid-high-phase for 5 cycles
        Enable = 1'b0;
        drive(1'b0, 3);
        Enable = 1'b1;
        drive(1'b0, 3);
        exp_p = 100;
        exp_h = 30;
        drive(1'b1, 30);
        drive(1'b0, 70);
        drive(1'b1, 10);
        base   = valid_cnt;
        Enable = 1'b0;
        drive(1'b1, 5);
        check("gap_no_valid", valid_cnt - base, 0);
        check("gap_period_held", Period, 100);
        check("gap_hightime_held", HighTime, 30);
        check("gap_stuck_held", StuckLevel, 1);
        Enable = 1'b1;
        drive(1'b1, 15);
        drive(1'b0, 70);
        drive(1'b1, 30);
        drive(1'b0, 70);
        check("reenable_discarded_period", valid_cnt - base, 0);
        drive(1'b1, 30);
        drive(1'b0, 70);
        drive(1'b0, 4);
        check("reenable_first_valid", valid_cnt - base, 1);
        check("reenable_period", Period, 100);
        check("reenable_hightime", HighTime, 30);

        // Asynchronous reset between edges in the middle of a measurement
        restart_enable();
        exp_p = 50;
        exp_h = 20;
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 20);
            drive(1'b0, 30);
        end
        check("pre_async_period", Period, 50);
        drive(1'b1, 8);
        #2;
        nReset = 1'b0;
        #1;
        check("async_period", Period, 0);
        check("async_hightime", HighTime, 0);
        check("async_valid", Valid, 0);
        check("async_timeout", Timeout, 0);
        check("async_stuck", StuckLevel, 0);
        drive(1'b1, 3);
        #3;
        nReset = 1'b1;
        base   = valid_cnt;
        drive(1'b1, 10);
        drive(1'b0, 30);
        check("post_reset_no_valid", valid_cnt - base, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
